mem_port: RTL and testbench
===========================

# mem_port

Memory-side responder for the multicycle CPU: the other end of the control unit's `mem_read`/`mem_write`/`data_or_not_inst` request lines. It accepts one 16-bit word request at a time, splits it into two byte-wide accesses to the external byte-wide memory, and returns read data or a write acknowledgement. The order is high byte first, low byte second, matching `hi_half` fetch order. Instruction and data spaces are selected by an extra top address bit.

## Interface
- `ADDR_WIDTH`, 16, CPU byte address width.
- `WAIT_STATES`, 1, extra cycles per byte access (0..7).
- `clk` in 1: clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: request strobe; sampled only while `req_ready`=1.
- `req_write` in 1: 1 = store (the `mem_write` role), 0 = load/fetch.
- `data_or_not_inst` in 1: 1 = data space, 0 = instruction space.
- `req_addr` in ADDR_WIDTH: word byte address; must be even.
- `req_wdata` in 16: store data.
- `req_ready` out 1: block idle and able to accept a request.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_rdata` out 16: load result; valid with `rsp_valid`; holds its value otherwise.
- `rsp_err` out 1: pulses with `rsp_valid` on a misaligned request.
- `ext_addr` out ADDR_WIDTH+1: `{data_or_not_inst, byte address}`.
- `ext_dout` out 8: byte driven toward memory.
- `ext_din` in 8: byte from memory.
- `ext_ce` out 1: memory chip enable.
- `ext_oe` out 1: bus drive enable for `ext_dout` (store phases only).
- `ext_we` out 1: byte write strobe.

## Operation
- Request fields are captured in internal registers on acceptance (`req_valid && req_ready`). Later input changes have no effect on the current request.
- `req_valid` while busy is ignored; no queueing.
- States: IDLE, HI, LO, RESP.
  - IDLE -> HI on an accepted, even address.
  - IDLE -> RESP on an accepted, odd address. `rsp_err`=1, no external access.
  - HI -> LO after WAIT_STATES+1 cycles.
  - LO -> RESP after WAIT_STATES+1 cycles.
  - RESP -> IDLE always.
- HI phase:
  - `ext_addr` = `{space, addr}`, `ext_ce`=1.
  - Load: `ext_din` is sampled into `rsp_rdata[15:8]` on the last cycle of the phase.
  - Store: `ext_oe`=1 and `ext_dout`=wdata[15:8] for the whole phase. `ext_we`=1 only on the last cycle of the phase, which gives address setup when WAIT_STATES>0.
- LO phase: identical to HI, using `addr+1` and byte [7:0].
- Address increment is modulo 2^ADDR_WIDTH and never carries into the space bit. Since `addr` is even, `addr+1` cannot wrap in practice.
- RESP: `rsp_valid`=1 for one cycle.
  - Load: `rsp_rdata` holds the full word.
  - Store: `rsp_rdata` is unchanged.
- A wait-state counter is reloaded on each phase entry. Width is 3 bits.
- `req_ready` = (state == IDLE); it is registered, not combinational from `req_valid`.
- All `ext_*` outputs are registered. Outside HI/LO, `ext_ce`, `ext_oe`, `ext_we` and `ext_dout` are 0, and `ext_addr` holds its last value.

## Timing
- Reset values:
  - state IDLE, `req_ready`=1.
  - `rsp_valid`, `rsp_err`, `ext_ce`, `ext_oe`, `ext_we` all 0.
  - `rsp_rdata`=0, `ext_dout`=0, `ext_addr`=0.
- Take cycle 0 as the acceptance edge (W = WAIT_STATES):
  - HI occupies cycles 1..W+1.
  - LO occupies cycles W+2..2W+2.
  - `rsp_valid` is asserted in cycle 2W+3.
  - `req_ready` is 0 in cycles 1..2W+3 and 1 again in cycle 2W+4.
- Misaligned request: `rsp_valid`=`rsp_err`=1 in cycle 1; `req_ready` returns in cycle 2.
- Back-to-back: a `req_valid` held high is accepted in the first cycle `req_ready`=1. The throughput is one word per 2W+4 cycles.
- Reset mid-operation, including mid-store: at the next edge every output takes its reset value and no `rsp_valid` is produced. A byte already strobed stays written; partial-word writes are permitted.
- `reset` and `req_valid` in the same cycle: reset wins and the request is dropped.

## Test plan
- Fetch, W=1, space 0, addr 0x0010, `ext_din` 0xAB then 0xCD:
  - `ext_addr` is 0x00010 in cycles 1–2 and 0x00011 in cycles 3–4.
  - `rsp_rdata`=0xABCD with `rsp_valid` in cycle 5.
- Data store, W=1, addr 0x0020, wdata 0x1234:
  - `ext_addr` 0x10020 with `ext_dout` 0x12 and `ext_we` in cycle 2 only.
  - `ext_addr` 0x10021 with `ext_dout` 0x34 and `ext_we` in cycle 4 only.
  - `rsp_valid` in cycle 5 with `rsp_rdata` unchanged.
- Misaligned load at addr 0x0003:
  - `rsp_valid`=`rsp_err`=1 in cycle 1.
  - `ext_ce` never rises.
  - Repeat with 0xFFFF: same result.
- W=0, data load at 0xFFFE with bytes 0x5A, 0xA5:
  - `ext_addr` 0x1FFFE then 0x1FFFF.
  - `rsp_rdata`=0x5AA5 in cycle 3.
  - A `req_valid` held high is re-accepted in cycle 4.
- Reset during the LO phase of a store:
  - At the next edge `ext_we`/`ext_oe`/`ext_ce`=0 and `req_ready`=1.
  - No `rsp_valid` ever follows.
  - A new load then completes normally.
- `req_valid` pulses while busy, with changing `req_addr`: they are ignored, and the in-flight access keeps its captured address.

Source files
------------

// File: rtl/mem_port.sv
// mem_port: memory-side responder for the multicycle CPU.
//
// Takes one 16-bit word request at a time and turns it into two byte-wide
// accesses on the external memory bus, high byte first (address addr), then
// low byte (address addr+1). Each byte access lasts WAIT_STATES+1 cycles.
// Loads return the assembled word with a one-cycle rsp_valid pulse. Stores
// return the same pulse as an acknowledgement. An odd request address is
// answered at once with rsp_valid and rsp_err, and no bus access is made.
//
// Parameters
//   ADDR_WIDTH   CPU byte address width
//   WAIT_STATES  extra cycles per byte access, 0..7
//
// Ports
//   clk               clock, rising edge
//   reset             synchronous, active-high
//   req_valid         request strobe, sampled only while req_ready=1
//   req_write         1 = store, 0 = load/fetch
//   data_or_not_inst  1 = data space, 0 = instruction space
//   req_addr          word byte address (must be even)
//   req_wdata         store data
//   req_ready         idle and able to accept a request (registered)
//   rsp_valid         one-cycle completion pulse
//   rsp_rdata         load result; holds its value between loads
//   rsp_err           misaligned-request flag, pulses with rsp_valid
//   ext_addr          {space, byte address} toward memory
//   ext_dout          byte driven toward memory
//   ext_din           byte from memory
//   ext_ce            memory chip enable
//   ext_oe            bus drive enable for ext_dout (store phases only)
//   ext_we            byte write strobe
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for a request; req_ready=1
// HI    | high-byte access at {space, addr}
// LO    | low-byte access at {space, addr+1}
// RESP  | rsp_valid pulse; back to IDLE on the next edge
module mem_port #(
  parameter int ADDR_WIDTH  = 16,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic                  data_or_not_inst,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [15:0]           req_wdata,
  output logic                  req_ready,
  output logic                  rsp_valid,
  output logic [15:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH:0]   ext_addr,
  output logic [7:0]            ext_dout,
  input  logic [7:0]            ext_din,
  output logic                  ext_ce,
  output logic                  ext_oe,
  output logic                  ext_we
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HI   = 2'd1,
    LO   = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [2:0]            WAIT_LOAD = 3'(WAIT_STATES);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                state_q;
  logic                  write_q;
  logic                  space_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [15:0]           wdata_q;
  logic [7:0]            hi_byte_q;
  logic [2:0]            wait_cnt_q;

  // The wait counter counts down from WAIT_STATES; a zero count marks the
  // last cycle of the current byte phase, which is where the read byte is
  // sampled and where the write strobe must already be showing.
  logic phase_last;
  assign phase_last = (wait_cnt_q == 3'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      write_q    <= 1'b0;
      space_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      hi_byte_q  <= '0;
      wait_cnt_q <= '0;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_rdata  <= '0;
      ext_addr   <= '0;
      ext_dout   <= '0;
      ext_ce     <= 1'b0;
      ext_oe     <= 1'b0;
      ext_we     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          if (req_valid && req_ready) begin
            write_q   <= req_write;
            space_q   <= data_or_not_inst;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            req_ready <= 1'b0;
            if (req_addr[0]) begin
              // Misaligned: answer immediately, leave the bus untouched.
              state_q   <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end else begin
              state_q    <= HI;
              wait_cnt_q <= WAIT_LOAD;
              ext_addr   <= {data_or_not_inst, req_addr};
              ext_ce     <= 1'b1;
              ext_oe     <= req_write;
              ext_dout   <= req_write ? req_wdata[15:8] : 8'h00;
              // With no wait states the first cycle is also the last one.
              ext_we     <= req_write && (WAIT_LOAD == 3'd0);
            end
          end
        end

        HI: begin
          if (phase_last) begin
            if (!write_q) begin
              hi_byte_q <= ext_din;
            end
            state_q    <= LO;
            wait_cnt_q <= WAIT_LOAD;
            ext_addr   <= {space_q, addr_q + ADDR_ONE};
            ext_dout   <= write_q ? wdata_q[7:0] : 8'h00;
            ext_we     <= write_q && (WAIT_LOAD == 3'd0);
          end else begin
            wait_cnt_q <= wait_cnt_q - 3'd1;
            // Raise the strobe so it is visible exactly in the final cycle.
            ext_we     <= write_q && (wait_cnt_q == 3'd1);
          end
        end

        LO: begin
          if (phase_last) begin
            // rsp_rdata is only updated here so it never shows a half word.
            if (!write_q) begin
              rsp_rdata <= {hi_byte_q, ext_din};
            end
            state_q   <= RESP;
            rsp_valid <= 1'b1;
            ext_ce    <= 1'b0;
            ext_oe    <= 1'b0;
            ext_we    <= 1'b0;
            ext_dout  <= 8'h00;
          end else begin
            wait_cnt_q <= wait_cnt_q - 3'd1;
            ext_we     <= write_q && (wait_cnt_q == 3'd1);
          end
        end

        RESP: begin
          state_q   <= IDLE;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          req_ready <= 1'b1;
        end

        default: begin
          state_q   <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          ext_ce    <= 1'b0;
          ext_oe    <= 1'b0;
          ext_we    <= 1'b0;
          ext_dout  <= 8'h00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port.sv
// Testbench for mem_port. Two instances share the request and memory-side
// inputs: index 1 runs with WAIT_STATES=1 and index 0 with WAIT_STATES=0.
// Each instance has its own req_valid. Expected per-cycle outputs come from
// the cycle-numbered timing rules of the block, not from its state machine.
module tb_mem_port;

  typedef struct packed {
    logic        ready;
    logic        valid;
    logic        err;
    logic [15:0] rdata;
    logic        ce;
    logic        oe;
    logic        we;
    logic [16:0] addr;
    logic [7:0]  dout;
  } obs_t;

  typedef struct {
    int          s;
    logic        wr;
    logic        sp;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [7:0]  dh;
    logic [7:0]  dl;
    logic [15:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       req_valid_v;
  logic             req_write;
  logic             data_or_not_inst;
  logic [15:0]      req_addr;
  logic [15:0]      req_wdata;
  logic [7:0]       ext_din;

  logic [1:0]       o_ready, o_valid, o_err, o_ce, o_oe, o_we;
  logic [1:0][15:0] o_rdata;
  logic [1:0][16:0] o_addr;
  logic [1:0][7:0]  o_dout;

  int checks   = 0;
  int failures = 0;

  logic [15:0] prev_rdata [2];
  logic [16:0] prev_addr  [2];

  always #5 clk = ~clk;

  mem_port #(.ADDR_WIDTH(16), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .reset(reset), .req_valid(req_valid_v[0]), .req_write(req_write),
    .data_or_not_inst(data_or_not_inst), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(o_ready[0]), .rsp_valid(o_valid[0]), .rsp_rdata(o_rdata[0]),
    .rsp_err(o_err[0]), .ext_addr(o_addr[0]), .ext_dout(o_dout[0]), .ext_din(ext_din),
    .ext_ce(o_ce[0]), .ext_oe(o_oe[0]), .ext_we(o_we[0])
  );

  mem_port #(.ADDR_WIDTH(16), .WAIT_STATES(1)) u_dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid_v[1]), .req_write(req_write),
    .data_or_not_inst(data_or_not_inst), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(o_ready[1]), .rsp_valid(o_valid[1]), .rsp_rdata(o_rdata[1]),
    .rsp_err(o_err[1]), .ext_addr(o_addr[1]), .ext_dout(o_dout[1]), .ext_din(ext_din),
    .ext_ce(o_ce[1]), .ext_oe(o_oe[1]), .ext_we(o_we[1])
  );

  function automatic obs_t get_obs(input int s);
    obs_t o;
    o.ready = o_ready[s];
    o.valid = o_valid[s];
    o.err   = o_err[s];
    o.rdata = o_rdata[s];
    o.ce    = o_ce[s];
    o.oe    = o_oe[s];
    o.we    = o_we[s];
    o.addr  = o_addr[s];
    o.dout  = o_dout[s];
    return o;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Expected outputs in cycle k after the acceptance edge (cycle 0), for the
  // instance whose wait-state count equals s.
  function automatic obs_t model(input int s, input int k, input logic wr, input logic sp,
                                 input logic [15:0] a, input logic [15:0] wd,
                                 input logic [7:0] dh, input logic [7:0] dl);
    obs_t e;
    int   w;
    logic hi, lo;
    w = s;
    e = '0;
    e.rdata = prev_rdata[s];
    e.addr  = prev_addr[s];
    if (a[0]) begin
      if (k == 1) begin
        e.valid = 1'b1;
        e.err   = 1'b1;
      end else begin
        e.ready = 1'b1;
      end
    end else begin
      hi = (k <= w + 1);
      lo = (k >= w + 2) && (k <= 2 * w + 2);
      e.ce = hi || lo;
      e.oe = wr && (hi || lo);
      e.we = wr && ((k == w + 1) || (k == 2 * w + 2));
      if (wr && hi) e.dout = wd[15:8];
      if (wr && lo) e.dout = wd[7:0];
      e.addr  = hi ? {sp, a} : {sp, a | 16'h0001};
      e.valid = (k == 2 * w + 3);
      e.ready = (k == 2 * w + 4);
      if (!wr && k >= 2 * w + 3) e.rdata = {dh, dl};
    end
    return e;
  endfunction

  // Issue one request on instance s (called away from clock edges while the
  // instance is idle) and check every cycle until it is ready again. With
  // noise set, req_valid pulses and the request fields change while busy.
  task automatic run_req(input int s, input logic wr, input logic sp,
                         input logic [15:0] a, input logic [15:0] wd,
                         input logic [7:0] dh, input logic [7:0] dl, input bit noise,
                         output logic [15:0] r_rdata, output logic r_err);
    int   n;
    obs_t o, e;
    n = a[0] ? 2 : 2 * s + 4;
    req_write        = wr;
    data_or_not_inst = sp;
    req_addr         = a;
    req_wdata        = wd;
    req_valid_v[s]   = 1'b1;
    @(posedge clk);
    #1;
    r_rdata = '0;
    r_err   = 1'b0;
    for (int k = 1; k <= n; k++) begin
      req_valid_v[s] = noise && (k < n) && ($urandom_range(0, 1) == 1);
      if (noise) begin
        req_addr         = 16'($urandom);
        req_wdata        = 16'($urandom);
        req_write        = 1'($urandom);
        data_or_not_inst = 1'($urandom);
      end
      if (!a[0] && k == s + 1)          ext_din = dh;
      else if (!a[0] && k == 2 * s + 2) ext_din = dl;
      else                              ext_din = 8'($urandom);
      @(negedge clk);
      o = get_obs(s);
      e = model(s, k, wr, sp, a, wd, dh, dl);
      check($sformatf("dut%0d addr %h cycle %0d", s, a, k), 64'(o), 64'(e));
      if (k == n - 1) begin
        r_rdata = o.rdata;
        r_err   = o.err;
      end
      if (k < n) begin
        @(posedge clk);
        #1;
      end
    end
    req_valid_v[s] = 1'b0;
    if (!a[0]) begin
      prev_addr[s] = {sp, a | 16'h0001};
      if (!wr) prev_rdata[s] = {dh, dl};
    end
  endtask

  vec_t vecs [5];

  initial begin
    obs_t        rst_obs, o;
    logic [15:0] r_rdata;
    logic        r_err;

    vecs[0] = '{1, 1'b0, 1'b0, 16'h0010, 16'h0000, 8'hAB, 8'hCD, 16'hABCD, 1'b0};
    vecs[1] = '{1, 1'b1, 1'b1, 16'h0020, 16'h1234, 8'h00, 8'h00, 16'hABCD, 1'b0};
    vecs[2] = '{1, 1'b0, 1'b0, 16'h0003, 16'h0000, 8'h11, 8'h22, 16'hABCD, 1'b1};
    vecs[3] = '{1, 1'b0, 1'b1, 16'hFFFF, 16'h0000, 8'h33, 8'h44, 16'hABCD, 1'b1};
    vecs[4] = '{0, 1'b0, 1'b1, 16'hFFFE, 16'h0000, 8'h5A, 8'hA5, 16'h5AA5, 1'b0};

    rst_obs       = '0;
    rst_obs.ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      prev_rdata[i] = '0;
      prev_addr[i]  = '0;
    end

    reset            = 1'b1;
    req_valid_v      = 2'b00;
    req_write        = 1'b0;
    data_or_not_inst = 1'b0;
    req_addr         = '0;
    req_wdata        = '0;
    ext_din          = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("reset dut0", 64'(get_obs(0)), 64'(rst_obs));
    check("reset dut1", 64'(get_obs(1)), 64'(rst_obs));

    // Directed vectors.
    for (int i = 0; i < 5; i++) begin
      run_req(vecs[i].s, vecs[i].wr, vecs[i].sp, vecs[i].addr, vecs[i].wdata,
              vecs[i].dh, vecs[i].dl, 1'b0, r_rdata, r_err);
      check($sformatf("vec%0d rsp_rdata", i), 64'(r_rdata), 64'(vecs[i].exp_rdata));
      check($sformatf("vec%0d rsp_err", i), 64'(r_err), 64'(vecs[i].exp_err));
    end

    // W=0: req_valid held high is re-accepted as soon as req_ready returns.
    ext_din          = 8'h77;
    req_write        = 1'b0;
    data_or_not_inst = 1'b0;
    req_addr         = 16'h0100;
    req_valid_v[0]   = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (k == 5) req_valid_v[0] = 1'b0;
      @(negedge clk);
      o = get_obs(0);
      if (k <= 3) check($sformatf("held ready low c%0d", k), 64'(o.ready), 64'(0));
      if (k == 3 || k == 7) begin
        check($sformatf("held rsp_valid c%0d", k), 64'(o.valid), 64'(1));
        check($sformatf("held rsp_rdata c%0d", k), 64'(o.rdata), 64'(16'h7777));
      end
      if (k == 4 || k == 8) check($sformatf("held ready c%0d", k), 64'(o.ready), 64'(1));
      if (k == 5) begin
        check("held reaccept ce", 64'(o.ce), 64'(1));
        check("held reaccept addr", 64'(o.addr), 64'(17'h00100));
      end
    end
    prev_rdata[0] = 16'h7777;
    prev_addr[0]  = 17'h00101;

    // Reset during the LO phase of a store on the W=1 instance.
    req_write        = 1'b1;
    data_or_not_inst = 1'b1;
    req_addr         = 16'h0040;
    req_wdata        = 16'hBEEF;
    req_valid_v[1]   = 1'b1;
    @(posedge clk);
    #1;
    req_valid_v[1] = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    o = get_obs(1);
    check("mid-store lo addr", 64'(o.addr), 64'(17'h10041));
    check("mid-store lo dout", 64'(o.dout), 64'(8'hEF));
    check("mid-store lo oe", 64'(o.oe), 64'(1));
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("reset mid-store dut1", 64'(get_obs(1)), 64'(rst_obs));
    check("reset mid-store dut0", 64'(get_obs(0)), 64'(rst_obs));
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check($sformatf("no rsp after reset %0d", k), 64'(o_valid[1]), 64'(0));
    end
    for (int i = 0; i < 2; i++) begin
      prev_rdata[i] = '0;
      prev_addr[i]  = '0;
    end
    run_req(1, 1'b0, 1'b1, 16'h0200, 16'h0000, 8'hC3, 8'h3C, 1'b0, r_rdata, r_err);
    check("load after reset", 64'(r_rdata), 64'(16'hC33C));

    // Reset and req_valid together: the request is dropped.
    reset            = 1'b1;
    req_write        = 1'b0;
    req_addr         = 16'h0080;
    req_valid_v      = 2'b11;
    @(posedge clk);
    #1;
    reset       = 1'b0;
    req_valid_v = 2'b00;
    @(negedge clk);
    check("reset+valid dut1", 64'(get_obs(1)), 64'(rst_obs));
    check("reset+valid dut0", 64'(get_obs(0)), 64'(rst_obs));
    @(negedge clk);
    check("reset+valid dut1 later", 64'(get_obs(1)), 64'(rst_obs));
    for (int i = 0; i < 2; i++) begin
      prev_rdata[i] = '0;
      prev_addr[i]  = '0;
    end

    // Random requests with busy-time noise.
    for (int i = 0; i < 60; i++) begin
      int          s;
      logic [15:0] a;
      s = $urandom_range(0, 1);
      a = 16'($urandom) & 16'hFFFE;
      if ($urandom_range(0, 4) == 0) a[0] = 1'b1;
      run_req(s, 1'($urandom), 1'($urandom), a, 16'($urandom),
              8'($urandom), 8'($urandom), 1'b1, r_rdata, r_err);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
